rdback_stream_tx: RTL and testbench
===================================

// Module: rdback_stream_tx
// PURPOSE
//  Downstream drain for the SoftMC read-back FIFO. Pops each DQ_WIDTH*4-bit entry,
//  serialises it into OUT_WIDTH-bit words and presents them on a valid/ready
//  stream toward the host bridge.
//  Drives rdback_fifo_rden from rdback_fifo_empty and rdback_data.
// PARAMETERS
//  DQ_WIDTH   64  DRAM data width; FIFO entry is 4*DQ_WIDTH bits
//  OUT_WIDTH  32  host stream word width; must divide 4*DQ_WIDTH (NWORDS = 4*DQ_WIDTH/OUT_WIDTH)
//  TCQ        100 clock-to-out delay on registered assignments (ps)
// PORTS
//  clk                 in   1            single clock
//  rst                 in   1            synchronous, active-high reset
//  rdback_fifo_empty   in   1            read-back FIFO empty
//  rdback_fifo_rden    out  1            FIFO pop; single-cycle pulse
//  rdback_data         in   4*DQ_WIDTH   FIFO dout; valid 1 cycle after rdback_fifo_rden (standard, non-FWFT)
//  tx_valid            out  1            output word valid
//  tx_ready            in   1            host accepts word when tx_valid & tx_ready
//  tx_data             out  OUT_WIDTH    output word
//  tx_last             out  1            high on the last word (NWORDS-1) of an entry
//  tx_busy             out  1            high in any state other than IDLE
// BEHAVIOUR
//  Reset: rdback_fifo_rden=0, tx_valid=0, tx_last=0, tx_data=0, tx_busy=0, word idx=0, state=IDLE.
//  FSM:
//   IDLE: if !rdback_fifo_empty -> pulse rdback_fifo_rden, go POP.
//   POP:  wait state; rdback_data becomes valid at the end of this cycle; go LOAD.
//   LOAD: capture rdback_data into shift register sr; idx=0; tx_valid=1; go SEND.
//   SEND: tx_data=sr[OUT_WIDTH-1:0] (least-significant word first).
//     On a tx_valid&tx_ready handshake: shift sr right by OUT_WIDTH; idx++.
//     If idx==NWORDS-1 at handshake:
//       if !rdback_fifo_empty: pulse rdback_fifo_rden, drop tx_valid, go POP.
//       else: drop tx_valid, go IDLE.
//  Outputs: tx_data, tx_valid and tx_last are registered. tx_last = (idx==NWORDS-1) while valid.
//  Holding rules:
//   - tx_data/tx_valid are held stable while tx_valid & !tx_ready; no word is dropped or duplicated.
//   - rdback_fifo_rden is never asserted while rdback_fifo_empty=1.
//   - At most one FIFO entry is outstanding; the bubble between entries is 2 cycles (POP, LOAD).
//  Latency: non-empty FIFO in IDLE -> first tx_valid 3 cycles later.
//  Throughput: with tx_ready tied high, NWORDS words per NWORDS+2 cycles.
//  rst asserted mid-entry: the remaining words are discarded; the FSM returns to IDLE next cycle.
//    An entry already popped from the FIFO is lost (a host-side flush is the accepted recovery).
//  idx width = $clog2(NWORDS); it never wraps past NWORDS-1.
// CONFIGURATION
//  RDBACK_TX_CNT_EN defined:
//   - adds output tx_entry_cnt [31:0], which counts entries fully sent (last-word handshakes).
//   - Counter is reset to 0 by rst, wraps modulo 2^32, and is usable by the host to check read totals.
//  RDBACK_TX_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package/include (softMC.inc): state encodings RDTX_IDLE/POP/LOAD/SEND (2-bit),
//  and the derived constant RDTX_NWORDS.
//  One natural sub-module, rdtx_shift_reg: a width-generic load/shift register with a word index.
//  All other logic stays flat in this module.
// TESTING
//  1. DQ_WIDTH=64, OUT_WIDTH=32; push one entry 0x..0807_0006_0005_..._0001 (word k=k+1), tx_ready=1
//     -> 8 words 1..8 in order; tx_last on word 8 only; one rden pulse; returns to IDLE.
//  2. Push 3 entries back-to-back, tx_ready=1 -> 24 words in order; exactly 3 rden pulses;
//     a 2-cycle bubble between entries.
//  3. Toggle tx_ready randomly at 50% -> tx_data stable while stalled; 8 unique words per entry;
//     no rden issued while empty.
//  4. Assert rst during word 4 of entry 1 with entry 2 queued -> outputs are 0 next cycle;
//     after release, entry 2 is sent in full starting at its word 1.
//  5. Empty FIFO for 100 cycles -> rden, tx_valid and tx_busy stay 0.
//  6. RDBACK_TX_CNT_EN defined: send 5 entries -> tx_entry_cnt=5.
//     Preload the counter to 0xFFFFFFFF via force, send 1 entry -> 0.

Source files
------------

// File: rtl/rdback_stream_tx_pkg.sv
// Shared definitions for the read-back stream drain: FSM state encodings and
// helpers deriving the word count and word-index width from the entry geometry.
package rdback_stream_tx_pkg;

    typedef enum logic [1:0] {
        RDTX_IDLE = 2'd0,
        RDTX_POP  = 2'd1,
        RDTX_LOAD = 2'd2,
        RDTX_SEND = 2'd3
    } rdtx_state_e;

    localparam int RDTX_DQ_WIDTH_DEF  = 64;
    localparam int RDTX_OUT_WIDTH_DEF = 32;

    function automatic int rdtx_nwords(input int dq_width, input int out_width);
        return (4 * dq_width) / out_width;
    endfunction

    // A single-word entry still gets a 1-bit index so the port never collapses.
    function automatic int rdtx_idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/rdback_stream_tx_shift_reg.sv
// Width-generic load/shift register: holds one FIFO entry, exposes the least-significant
// word, and tracks which word of the entry is currently presented.
module rdtx_shift_reg #(
    parameter int WIDTH      = 256,
    parameter int WORD_WIDTH = 32,
    parameter int NWORDS     = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WIDTH-1:0]      din,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  last,
    output logic                  pre_last
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NWORDS - 1);

    logic [WIDTH-1:0]     sr;
    logic [IDX_WIDTH-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            idx <= '0;
        end else if (load) begin
            sr  <= din;
            idx <= '0;
        end else if (shift) begin
            sr <= sr >> WORD_WIDTH;
            // Index saturates on the last word; the next load restarts it.
            if (idx != IDX_LAST) begin
                idx <= idx + IDX_WIDTH'(1);
            end
        end
    end

    assign word     = sr[WORD_WIDTH-1:0];
    assign last     = (idx == IDX_LAST);
    assign pre_last = (NWORDS > 1) && (idx == IDX_LAST - IDX_WIDTH'(1));

endmodule

// File: rtl/rdback_stream_tx.sv
// Drains the SoftMC read-back FIFO and serialises each entry LSW-first onto a
// valid/ready stream. Optional entry counter port enabled by RDBACK_TX_CNT_EN.
module rdback_stream_tx
    import rdback_stream_tx_pkg::*;
#(
    parameter int DQ_WIDTH  = RDTX_DQ_WIDTH_DEF,
    parameter int OUT_WIDTH = RDTX_OUT_WIDTH_DEF,
    parameter int TCQ       = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdback_fifo_empty,
    output logic                  rdback_fifo_rden,
    input  logic [4*DQ_WIDTH-1:0] rdback_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [OUT_WIDTH-1:0]  tx_data,
    output logic                  tx_last,
    output logic                  tx_busy
`ifdef RDBACK_TX_CNT_EN
    ,
    output logic [31:0]           tx_entry_cnt
`endif
);

    localparam int RDTX_NWORDS = rdtx_nwords(DQ_WIDTH, OUT_WIDTH);
    localparam int IDX_WIDTH   = rdtx_idx_width(RDTX_NWORDS);

    // TCQ is a clock-to-out annotation for simulation models only; it is checked, not applied.
    if (((4 * DQ_WIDTH) % OUT_WIDTH) != 0 || TCQ < 0) begin : g_bad_param
        $error("rdback_stream_tx: OUT_WIDTH must divide 4*DQ_WIDTH and TCQ must be non-negative");
    end

    // Stream handshake: a word transfers on any rising edge where tx_valid and tx_ready
    // are both high; while tx_valid is high and tx_ready low, tx_data and tx_last hold.
    rdtx_state_e state;
    logic        sr_load;
    logic        sr_last;
    logic        sr_pre_last;
    logic        handshake;

    assign sr_load   = (state == RDTX_LOAD);
    assign handshake = (state == RDTX_SEND) && tx_valid && tx_ready;
    assign tx_busy   = (state != RDTX_IDLE);

    rdtx_shift_reg #(
        .WIDTH      (4 * DQ_WIDTH),
        .WORD_WIDTH (OUT_WIDTH),
        .NWORDS     (RDTX_NWORDS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (handshake),
        .din      (rdback_data),
        .word     (tx_data),
        .last     (sr_last),
        .pre_last (sr_pre_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RDTX_IDLE;
            rdback_fifo_rden <= 1'b0;
            tx_valid         <= 1'b0;
            tx_last          <= 1'b0;
        end else begin
            rdback_fifo_rden <= 1'b0;
            case (state)
                RDTX_IDLE: begin
                    if (!rdback_fifo_empty) begin
                        rdback_fifo_rden <= 1'b1;
                        state            <= RDTX_POP;
                    end
                end
                RDTX_POP: begin
                    state <= RDTX_LOAD;
                end
                RDTX_LOAD: begin
                    tx_valid <= 1'b1;
                    tx_last  <= (RDTX_NWORDS == 1);
                    state    <= RDTX_SEND;
                end
                RDTX_SEND: begin
                    if (handshake) begin
                        if (sr_last) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            // Chain straight into the next entry to keep the bubble at two cycles.
                            if (!rdback_fifo_empty) begin
                                rdback_fifo_rden <= 1'b1;
                                state            <= RDTX_POP;
                            end else begin
                                state <= RDTX_IDLE;
                            end
                        end else begin
                            tx_last <= sr_pre_last;
                        end
                    end
                end
                default: begin
                    state <= RDTX_IDLE;
                end
            endcase
        end
    end

`ifdef RDBACK_TX_CNT_EN
    logic [31:0] entry_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_cnt <= '0;
        end else if (handshake && sr_last) begin
            entry_cnt <= entry_cnt + 32'd1;
        end
    end

    assign tx_entry_cnt = entry_cnt;
`endif

endmodule

// File: tb/tb_rdback_stream_tx.sv
// Directed bench for rdback_stream_tx with a non-FWFT FIFO model and a word scoreboard;
// the counter test runs when RDBACK_TX_CNT_EN is defined.
module tb_rdback_stream_tx;

    localparam int DQ_WIDTH  = 64;
    localparam int OUT_WIDTH = 32;
    localparam int EW        = 4 * DQ_WIDTH;
    localparam int NW        = EW / OUT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rdback_fifo_empty = 1'b1;
    logic                 rdback_fifo_rden;
    logic [EW-1:0]        rdback_data = '0;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic [OUT_WIDTH-1:0] tx_data;
    logic                 tx_last;
    logic                 tx_busy;
`ifdef RDBACK_TX_CNT_EN
    logic [31:0]          tx_entry_cnt;
`endif

    always #5 clk = ~clk;

    rdback_stream_tx #(
        .DQ_WIDTH  (DQ_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .TCQ       (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdback_fifo_empty (rdback_fifo_empty),
        .rdback_fifo_rden  (rdback_fifo_rden),
        .rdback_data       (rdback_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_data           (tx_data),
        .tx_last           (tx_last),
        .tx_busy           (tx_busy)
`ifdef RDBACK_TX_CNT_EN
        ,
        .tx_entry_cnt      (tx_entry_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: standard read latency, dout updates the cycle after rden.
    logic          push_en = 1'b0;
    logic [EW-1:0] push_data = '0;
    logic [EW-1:0] fifo_q[$];

    always @(posedge clk) begin
        if (rdback_fifo_rden && fifo_q.size() > 0) begin
            rdback_data <= fifo_q.pop_front();
        end
        if (push_en) begin
            fifo_q.push_back(push_data);
        end
        rdback_fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard and ready driver, both at the falling edge.
    logic [OUT_WIDTH-1:0] exp_q[$];
    int                   mon_idx    = 0;
    int                   mon_words  = 0;
    int                   rden_cnt   = 0;
    int                   ready_mode = 0;
    int                   gap        = 0;
    bit                   gap_armed  = 1'b0;
    bit                   gap_check  = 1'b0;
    bit                   stall_prev = 1'b0;
    logic [OUT_WIDTH-1:0] data_prev  = '0;

    always @(negedge clk) begin
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
        if (rst) begin
            mon_idx    = 0;
            stall_prev = 1'b0;
            gap_armed  = 1'b0;
        end else begin
            if (rdback_fifo_rden) begin
                rden_cnt++;
                chk("rden_while_empty", rdback_fifo_empty, 0);
            end
            if (stall_prev) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, data_prev);
            end
            if (gap_armed) begin
                if (tx_valid) begin
                    if (gap_check) chk("bubble_cycles", gap, 2);
                    gap_armed = 1'b0;
                end else if (!tx_busy) begin
                    gap_armed = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word_qsize", exp_q.size(), 1);
                end else begin
                    chk("word", tx_data, exp_q.pop_front());
                    chk("last", tx_last, mon_idx == NW - 1);
                end
                mon_words++;
                if (mon_idx == NW - 1) begin
                    mon_idx   = 0;
                    gap       = 0;
                    gap_armed = 1'b1;
                end else begin
                    mon_idx++;
                end
            end
            stall_prev = tx_valid && !tx_ready;
            data_prev  = tx_data;
        end
    end

    function automatic logic [EW-1:0] mk_entry(input int base);
        logic [EW-1:0] e;
        e = '0;
        for (int k = 0; k < NW; k++) e[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(base + k);
        return e;
    endfunction

    task automatic push_entry(input logic [EW-1:0] e);
        push_en   = 1'b1;
        push_data = e;
        for (int k = 0; k < NW; k++) exp_q.push_back(e[k*OUT_WIDTH +: OUT_WIDTH]);
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || tx_busy || !rdback_fifo_empty) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_drain_timeout"}, cyc >= 2000, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, cyc;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_rden", rdback_fifo_rden, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", tx_busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single entry, words 1..8, ready high.
        r0 = rden_cnt; w0 = mon_words;
        push_entry(mk_entry(1));
        cyc = 0;
        while (!tx_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("first_valid_latency", cyc, 3);
        wait_drain("t1");
        chk("t1_rden_pulses", rden_cnt - r0, 1);
        chk("t1_words", mon_words - w0, 8);
        chk("t1_idle", tx_busy, 0);

        // Three back-to-back entries, bubble checked by the scoreboard.
        r0 = rden_cnt; w0 = mon_words;
        gap_check = 1'b1;
        push_entry(mk_entry(32'h101));
        push_entry(mk_entry(32'h201));
        push_entry(mk_entry(32'h301));
        wait_drain("t2");
        gap_check = 1'b0;
        chk("t2_rden_pulses", rden_cnt - r0, 3);
        chk("t2_words", mon_words - w0, 24);

        // Random backpressure.
        r0 = rden_cnt; w0 = mon_words;
        ready_mode = 1;
        push_entry(mk_entry(32'h1000));
        push_entry(mk_entry(32'h2000));
        push_entry(mk_entry(32'h3000));
        wait_drain("t3");
        ready_mode = 0;
        @(negedge clk);
        chk("t3_rden_pulses", rden_cnt - r0, 3);
        chk("t3_words", mon_words - w0, 24);

        // Reset while word 4 of entry A is presented, entry B still queued.
        r0 = rden_cnt; w0 = mon_words;
        push_entry(mk_entry(32'h4000));
        push_entry(mk_entry(32'h5000));
        cyc = 0;
        while (mon_words < w0 + 3 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        chk("t4_reach_word4_timeout", cyc >= 200, 0);
        ready_mode = 2;
        @(negedge clk);
        chk("t4_word4_presented", tx_data, 32'h4003);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_valid", tx_valid, 0);
        chk("t4_rst_data", tx_data, 0);
        chk("t4_rst_last", tx_last, 0);
        chk("t4_rst_rden", rdback_fifo_rden, 0);
        chk("t4_rst_busy", tx_busy, 0);
        repeat (5) void'(exp_q.pop_front());
        rst = 1'b0;
        ready_mode = 0;
        wait_drain("t4");
        chk("t4_rden_pulses", rden_cnt - r0, 2);
        chk("t4_words", mon_words - w0, 11);

        // Empty FIFO stays quiet.
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen |= rdback_fifo_rden | tx_valid | tx_busy;
        end
        chk("t5_idle_quiet", seen, 0);

`ifdef RDBACK_TX_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_cnt_after_rst", tx_entry_cnt, 0);
        for (int n = 0; n < 5; n++) push_entry(mk_entry(32'h6000 + n * 16));
        wait_drain("t6a");
        chk("t6_cnt_five", tx_entry_cnt, 5);
        force dut.entry_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.entry_cnt;
        push_entry(mk_entry(32'h7000));
        wait_drain("t6b");
        chk("t6_cnt_wrap", tx_entry_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
